// File: rtl/vpu_pkg.sv
// Shared types and default sizing for the VPU destination-side datapath.
// The collector FSM state type and write-word width live here so the source port can reuse them.
package vpu_pkg;

   localparam int VPU_OPERAND_WIDTH = 32;
   localparam int DST_LANE_CNT      = 4;
   localparam int DST_FIFO_DEPTH    = 8;
   localparam int DST_ADDR_WIDTH    = 8;
   localparam int DST_LEN_WIDTH     = 8;
   localparam int WR_DATA_WIDTH     = VPU_OPERAND_WIDTH * DST_LANE_CNT;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PACK  = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } collector_state_t;

endpackage

// File: rtl/vpu_sync_fifo.sv
// Single-clock FIFO; a push is poppable the next cycle. Push on full is ignored unless
// a pop happens in the same cycle, which keeps simultaneous push/pop on full lossless.
module vpu_sync_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 8,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = AW + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic [WIDTH-1:0] push_dat_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] pop_dat_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [CW-1:0]    count_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push, do_pop;

   assign full_o    = (count_q == CW'(DEPTH));
   assign empty_o   = (count_q == '0);
   assign count_o   = count_q;
   assign pop_dat_o = mem_q[rd_ptr_q];

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      do_pop   = pop_i && !empty_o;
      do_push  = push_i && (!full_o || do_pop);
      if (do_push) begin
         mem_d[wr_ptr_q] = push_dat_i;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      count_d = count_q + CW'(do_push) - CW'(do_pop);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: the pointers and count define which entries are live.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/vpu_dst_collector.sv
// Buffers an unstallable FP result stream, packs LANE_CNT results per word and writes them to the
// register file (valid/ready, held while stalled). Credits keep results from ever outrunning the FIFO.
module vpu_dst_collector
   import vpu_pkg::*;
#(
   parameter int OPERAND_WIDTH = VPU_OPERAND_WIDTH,
   parameter int LANE_CNT      = DST_LANE_CNT,
   parameter int FIFO_DEPTH    = DST_FIFO_DEPTH,
   parameter int ADDR_WIDTH    = DST_ADDR_WIDTH,
   parameter int LEN_WIDTH     = DST_LEN_WIDTH
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              start_i,
   output logic                              issue_ready_o,
   input  logic                              result_valid_i,
   input  logic [OPERAND_WIDTH-1:0]          result_i,
   input  logic                              cfg_start_i,
   input  logic [ADDR_WIDTH-1:0]             cfg_base_addr_i,
   input  logic [LEN_WIDTH-1:0]              cfg_len_i,
   output logic                              wr_valid_o,
   input  logic                              wr_ready_i,
   output logic [ADDR_WIDTH-1:0]             wr_addr_o,
   output logic [OPERAND_WIDTH*LANE_CNT-1:0] wr_data_o,
   output logic                              done_o,
   output logic                              err_o
);

   localparam int LW = $clog2(LANE_CNT);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam int IW = $clog2(FIFO_DEPTH) + 2;

   collector_state_t       state_q, state_d;
   logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
   logic [LEN_WIDTH-1:0]   rem_q, rem_d;
   logic [LW-1:0]          lane_q, lane_d;
   logic [OPERAND_WIDTH-1:0] lane_buf_q [LANE_CNT];
   logic [OPERAND_WIDTH-1:0] lane_buf_d [LANE_CNT];
   logic [IW-1:0]          inflight_q, inflight_d;
   logic                   issue_ready_q, issue_ready_d;
   logic                   err_q, err_d;

   logic                     fifo_pop, fifo_full, fifo_empty, push_ok, inflight_dec;
   logic [OPERAND_WIDTH-1:0] fifo_dat;
   logic [CW-1:0]            fifo_count, fifo_count_next;
   logic [IW-1:0]            occ_next;

   vpu_sync_fifo #(
      .WIDTH (OPERAND_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .push_i     (result_valid_i),
      .push_dat_i (result_i),
      .pop_i      (fifo_pop),
      .pop_dat_o  (fifo_dat),
      .full_o     (fifo_full),
      .empty_o    (fifo_empty),
      .count_o    (fifo_count)
   );

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      rem_d      = rem_q;
      lane_d     = lane_q;
      lane_buf_d = lane_buf_q;
      fifo_pop   = 1'b0;
      case (state_q)
         IDLE: begin
            if (cfg_start_i) begin
               addr_d  = cfg_base_addr_i;
               rem_d   = cfg_len_i;
               lane_d  = '0;
               state_d = (cfg_len_i == '0) ? DONE : PACK;
            end
         end
         PACK: begin
            if (!fifo_empty) begin
               fifo_pop           = 1'b1;
               lane_buf_d[lane_q] = fifo_dat;
               lane_d             = lane_q + 1'b1;
               if (lane_q == LW'(LANE_CNT - 1)) begin
                  state_d = WRITE;
               end
            end
         end
         WRITE: begin
            if (wr_ready_i) begin
               addr_d  = addr_q + 1'b1;
               rem_d   = rem_q - 1'b1;
               lane_d  = '0;
               state_d = (rem_q == LEN_WIDTH'(1)) ? DONE : PACK;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Credit accounting looks one cycle ahead so issue_ready_q is exact in the cycle it is seen.
   always_comb begin
      inflight_dec = result_valid_i && (inflight_q != '0);
      push_ok      = result_valid_i && (!fifo_full || fifo_pop);
      inflight_d   = inflight_q;
      if (start_i && !result_valid_i) begin
         inflight_d = inflight_q + 1'b1;
      end else if (!start_i && inflight_dec) begin
         inflight_d = inflight_q - 1'b1;
      end
      fifo_count_next = fifo_count + CW'(push_ok) - CW'(fifo_pop);
      occ_next        = inflight_d + IW'(fifo_count_next);
      issue_ready_d   = (occ_next < IW'(FIFO_DEPTH));
      err_d           = err_q
                      || (result_valid_i && (inflight_q == '0))
                      || (result_valid_i && !push_ok);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         addr_q        <= '0;
         rem_q         <= '0;
         lane_q        <= '0;
         inflight_q    <= '0;
         issue_ready_q <= 1'b0;
         err_q         <= 1'b0;
         for (int i = 0; i < LANE_CNT; i++) begin
            lane_buf_q[i] <= '0;
         end
      end else begin
         state_q       <= state_d;
         addr_q        <= addr_d;
         rem_q         <= rem_d;
         lane_q        <= lane_d;
         inflight_q    <= inflight_d;
         issue_ready_q <= issue_ready_d;
         err_q         <= err_d;
         lane_buf_q    <= lane_buf_d;
      end
   end

   always_comb begin
      wr_data_o = '0;
      for (int i = 0; i < LANE_CNT; i++) begin
         wr_data_o[i*OPERAND_WIDTH +: OPERAND_WIDTH] = lane_buf_q[i];
      end
   end

   assign wr_valid_o    = (state_q == WRITE);
   assign wr_addr_o     = addr_q;
   assign done_o        = (state_q == DONE);
   assign issue_ready_o = issue_ready_q;
   assign err_o         = err_q;

endmodule
